// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates up to two tags per cycle at dispatch,
// collects two writebacks per cycle, retires up to two completed
// non-speculative entries per cycle in program order, and drops the
// speculative tail on a mispredict.
module reorder_buffer #(
  parameter int NUM_ENTRIES = 32,
  parameter int ROB_ADDR_W  = 5,
  parameter int REG_ADDR_W  = 5,
  parameter int DATA_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alloc0,
  input  logic                  alloc1,
  input  logic [REG_ADDR_W-1:0] alloc_reg_addr0,
  input  logic [REG_ADDR_W-1:0] alloc_reg_addr1,
  input  logic                  alloc_spec0,
  input  logic                  alloc_spec1,
  output logic                  alloc_ready,
  output logic [ROB_ADDR_W-1:0] alloc_rob_addr0,
  output logic [ROB_ADDR_W-1:0] alloc_rob_addr1,
  input  logic                  wb0,
  input  logic                  wb1,
  input  logic [ROB_ADDR_W-1:0] wb_rob_addr0,
  input  logic [ROB_ADDR_W-1:0] wb_rob_addr1,
  input  logic [DATA_W-1:0]     wb_data0,
  input  logic [DATA_W-1:0]     wb_data1,
  input  logic [ROB_ADDR_W-1:0] rd_rob_addr0,
  input  logic [ROB_ADDR_W-1:0] rd_rob_addr1,
  output logic                  rd_done0,
  output logic                  rd_done1,
  output logic [DATA_W-1:0]     rd_data0,
  output logic [DATA_W-1:0]     rd_data1,
  input  logic                  spec_clear,
  input  logic                  flush,
  output logic                  retire0,
  output logic                  retire1,
  output logic [REG_ADDR_W-1:0] retire_reg_addr0,
  output logic [REG_ADDR_W-1:0] retire_reg_addr1,
  output logic [ROB_ADDR_W-1:0] retire_rob_addr0,
  output logic [ROB_ADDR_W-1:0] retire_rob_addr1,
  output logic [DATA_W-1:0]     retire_data0,
  output logic [DATA_W-1:0]     retire_data1,
  output logic [ROB_ADDR_W:0]   count
);

  typedef logic [ROB_ADDR_W-1:0] tag_t;
  typedef logic [ROB_ADDR_W:0]   cnt_t;

  // Control state (reset)
  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [NUM_ENTRIES-1:0] done_q, done_d;
  logic [NUM_ENTRIES-1:0] spec_q, spec_d;
  tag_t                   head_q, head_d;
  tag_t                   tail_q, tail_d;
  cnt_t                   count_q, count_d;

  // Payload state (not reset; only observed while the entry is valid)
  logic [REG_ADDR_W-1:0]  reg_q  [NUM_ENTRIES];
  logic [REG_ADDR_W-1:0]  reg_d  [NUM_ENTRIES];
  logic [DATA_W-1:0]      data_q [NUM_ENTRIES];
  logic [DATA_W-1:0]      data_d [NUM_ENTRIES];

  tag_t head1;
  cnt_t n_ret;
  cnt_t n_alloc;
  cnt_t nonspec;

  assign head1           = head_q + tag_t'(1);
  assign alloc_ready     = (count_q <= cnt_t'(NUM_ENTRIES - 2));
  assign alloc_rob_addr0 = tail_q;
  assign alloc_rob_addr1 = tail_q + tag_t'(alloc0);

  // Retire needs a done, committed entry at head; slot 1 only behind slot 0.
  assign retire0          = valid_q[head_q] & done_q[head_q] & ~spec_q[head_q];
  assign retire1          = retire0 & valid_q[head1] & done_q[head1] & ~spec_q[head1];
  assign retire_reg_addr0 = reg_q[head_q];
  assign retire_reg_addr1 = reg_q[head1];
  assign retire_rob_addr0 = head_q;
  assign retire_rob_addr1 = head1;
  assign retire_data0     = data_q[head_q];
  assign retire_data1     = data_q[head1];

  // Operand lookup reads registered state only: no writeback bypass.
  assign rd_done0 = valid_q[rd_rob_addr0] & done_q[rd_rob_addr0];
  assign rd_done1 = valid_q[rd_rob_addr1] & done_q[rd_rob_addr1];
  assign rd_data0 = data_q[rd_rob_addr0];
  assign rd_data1 = data_q[rd_rob_addr1];

  assign count = count_q;

  // Next state: writeback, retire, then flush or spec_clear + allocate.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    spec_d  = spec_q;
    reg_d   = reg_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    nonspec = '0;
    n_alloc = '0;
    n_ret   = cnt_t'(retire0) + cnt_t'(retire1);

    // Port 1 is applied last so it wins a same-tag collision.
    if (wb0 && valid_q[wb_rob_addr0]) begin
      done_d[wb_rob_addr0] = 1'b1;
      data_d[wb_rob_addr0] = wb_data0;
    end
    if (wb1 && valid_q[wb_rob_addr1]) begin
      done_d[wb_rob_addr1] = 1'b1;
      data_d[wb_rob_addr1] = wb_data1;
    end

    if (retire0) valid_d[head_q] = 1'b0;
    if (retire1) valid_d[head1]  = 1'b0;
    head_d = head_q + tag_t'(n_ret);

    if (flush) begin
      // Speculative entries form the youngest run, so the surviving
      // committed entries end exactly head + nonspec.
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (valid_q[i] && !spec_q[i]) nonspec = nonspec + cnt_t'(1);
        if (spec_q[i]) begin
          valid_d[i] = 1'b0;
          done_d[i]  = 1'b0;
          spec_d[i]  = 1'b0;
        end
      end
      tail_d  = head_q + tag_t'(nonspec);
      count_d = nonspec - n_ret;
    end else begin
      if (spec_clear) spec_d = '0;
      if (alloc_ready) begin
        if (alloc0) begin
          valid_d[alloc_rob_addr0] = 1'b1;
          done_d[alloc_rob_addr0]  = 1'b0;
          spec_d[alloc_rob_addr0]  = alloc_spec0;
          reg_d[alloc_rob_addr0]   = alloc_reg_addr0;
        end
        if (alloc1) begin
          valid_d[alloc_rob_addr1] = 1'b1;
          done_d[alloc_rob_addr1]  = 1'b0;
          spec_d[alloc_rob_addr1]  = alloc_spec1;
          reg_d[alloc_rob_addr1]   = alloc_reg_addr1;
        end
        n_alloc = cnt_t'(alloc0) + cnt_t'(alloc1);
      end
      tail_d  = tail_q + tag_t'(n_alloc);
      count_d = count_q + n_alloc - n_ret;
    end
  end

  // Control registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      done_q  <= '0;
      spec_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      spec_q  <= spec_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload registers; contents are qualified by valid/done.
  always_ff @(posedge clk) begin
    reg_q  <= reg_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a per-cycle vector table for the basic
// alloc/writeback/retire flow, then hand-written sequences for fill/wrap,
// flush, spec_clear and asynchronous reset.
module tb_reorder_buffer;
  localparam int NE = 32;
  localparam int AW = 5;
  localparam int RW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          alloc0, alloc1, alloc_spec0, alloc_spec1;
  logic [RW-1:0] alloc_reg_addr0, alloc_reg_addr1;
  logic          alloc_ready;
  logic [AW-1:0] alloc_rob_addr0, alloc_rob_addr1;
  logic          wb0, wb1;
  logic [AW-1:0] wb_rob_addr0, wb_rob_addr1;
  logic [DW-1:0] wb_data0, wb_data1;
  logic [AW-1:0] rd_rob_addr0, rd_rob_addr1;
  logic          rd_done0, rd_done1;
  logic [DW-1:0] rd_data0, rd_data1;
  logic          spec_clear, flush;
  logic          retire0, retire1;
  logic [RW-1:0] retire_reg_addr0, retire_reg_addr1;
  logic [AW-1:0] retire_rob_addr0, retire_rob_addr1;
  logic [DW-1:0] retire_data0, retire_data1;
  logic [AW:0]   count;

  int checks = 0;
  int failures = 0;

  reorder_buffer #(.NUM_ENTRIES(NE), .ROB_ADDR_W(AW), .REG_ADDR_W(RW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .alloc0(alloc0), .alloc1(alloc1),
    .alloc_reg_addr0(alloc_reg_addr0), .alloc_reg_addr1(alloc_reg_addr1),
    .alloc_spec0(alloc_spec0), .alloc_spec1(alloc_spec1),
    .alloc_ready(alloc_ready),
    .alloc_rob_addr0(alloc_rob_addr0), .alloc_rob_addr1(alloc_rob_addr1),
    .wb0(wb0), .wb1(wb1),
    .wb_rob_addr0(wb_rob_addr0), .wb_rob_addr1(wb_rob_addr1),
    .wb_data0(wb_data0), .wb_data1(wb_data1),
    .rd_rob_addr0(rd_rob_addr0), .rd_rob_addr1(rd_rob_addr1),
    .rd_done0(rd_done0), .rd_done1(rd_done1),
    .rd_data0(rd_data0), .rd_data1(rd_data1),
    .spec_clear(spec_clear), .flush(flush),
    .retire0(retire0), .retire1(retire1),
    .retire_reg_addr0(retire_reg_addr0), .retire_reg_addr1(retire_reg_addr1),
    .retire_rob_addr0(retire_rob_addr0), .retire_rob_addr1(retire_rob_addr1),
    .retire_data0(retire_data0), .retire_data1(retire_data1),
    .count(count)
  );

  always #5 clk = ~clk;

  // One row = inputs for one cycle plus outputs expected before its edge.
  typedef struct {
    int a0, a1, ar0, ar1;
    int w0, w1, wt0, wt1, wd0, wd1;
    int rt;
    int e_cnt, e_rdy, e_t0, e_t1;
    int e_r0, e_r1, e_rr0, e_rr1, e_rtag, e_rd0, e_rd1;
    int e_rdn, e_rdd;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];
  vec_t v;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    alloc0 = 1'b0; alloc1 = 1'b0; alloc_spec0 = 1'b0; alloc_spec1 = 1'b0;
    alloc_reg_addr0 = '0; alloc_reg_addr1 = '0;
    wb0 = 1'b0; wb1 = 1'b0; wb_rob_addr0 = '0; wb_rob_addr1 = '0;
    wb_data0 = '0; wb_data1 = '0;
    rd_rob_addr0 = '0; rd_rob_addr1 = '0;
    spec_clear = 1'b0; flush = 1'b0;
  endtask

  // Advance one clock; leaves the bench just after the falling edge.
  task automatic next();
    @(negedge clk);
    clr();
  endtask

  task automatic do_reset();
    clr();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    //            a0 a1 ar0 ar1 w0 w1 wt0 wt1 wd0      wd1      rt  cnt rdy t0 t1 r0 r1 rr0 rr1 rtag rd0      rd1      rdn rdd
    vecs[0]  = '{1, 1, 3,  4,  0, 0, 0,  0,  0,       0,       0,  0,  1,  0, 1, 0, 0, 0,  0,  0,   0,       0,       0,  0};
    vecs[1]  = '{0, 0, 0,  0,  0, 1, 0,  1,  0,       'hBEEF,  1,  2,  1,  2, 2, 0, 0, 0,  0,  0,   0,       0,       0,  0};
    vecs[2]  = '{0, 0, 0,  0,  1, 0, 0,  0,  'h1234,  0,       1,  2,  1,  2, 2, 0, 0, 0,  0,  0,   0,       0,       1,  'hBEEF};
    vecs[3]  = '{0, 0, 0,  0,  0, 0, 0,  0,  0,       0,       0,  2,  1,  2, 2, 1, 1, 3,  4,  0,   'h1234,  'hBEEF,  1,  'h1234};
    vecs[4]  = '{1, 0, 7,  0,  0, 0, 0,  0,  0,       0,       0,  0,  1,  2, 3, 0, 0, 0,  0,  0,   0,       0,       0,  0};
    vecs[5]  = '{0, 0, 0,  0,  1, 1, 2,  2,  'h1111,  'h2222,  2,  1,  1,  3, 3, 0, 0, 0,  0,  0,   0,       0,       0,  0};
    vecs[6]  = '{0, 0, 0,  0,  1, 0, 9,  0,  'h9999,  0,       2,  1,  1,  3, 3, 1, 0, 7,  0,  2,   'h2222,  0,       1,  'h2222};
    vecs[7]  = '{0, 1, 0,  5,  0, 0, 0,  0,  0,       0,       9,  0,  1,  3, 3, 0, 0, 0,  0,  0,   0,       0,       0,  0};
    vecs[8]  = '{0, 0, 0,  0,  1, 0, 3,  0,  'h55,    0,       3,  1,  1,  4, 4, 0, 0, 0,  0,  0,   0,       0,       0,  0};
    vecs[9]  = '{0, 0, 0,  0,  0, 0, 0,  0,  0,       0,       3,  1,  1,  4, 4, 1, 0, 5,  0,  3,   'h55,    0,       1,  'h55};
    vecs[10] = '{0, 0, 0,  0,  0, 0, 0,  0,  0,       0,       3,  0,  1,  4, 4, 0, 0, 0,  0,  0,   0,       0,       0,  0};

    clr();
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_ready", int'(alloc_ready), 1);
    chk("rst_tag0", int'(alloc_rob_addr0), 0);
    chk("rst_tag1", int'(alloc_rob_addr1), 0);
    chk("rst_retire0", int'(retire0), 0);
    chk("rst_retire1", int'(retire1), 0);
    chk("rst_rd_done0", int'(rd_done0), 0);
    chk("rst_rd_done1", int'(rd_done1), 0);
    reset = 1'b1;

    // ---------------- vector table ----------------
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      alloc0 = v.a0[0]; alloc1 = v.a1[0];
      alloc_reg_addr0 = v.ar0[RW-1:0]; alloc_reg_addr1 = v.ar1[RW-1:0];
      wb0 = v.w0[0]; wb1 = v.w1[0];
      wb_rob_addr0 = v.wt0[AW-1:0]; wb_rob_addr1 = v.wt1[AW-1:0];
      wb_data0 = v.wd0; wb_data1 = v.wd1;
      rd_rob_addr0 = v.rt[AW-1:0];
      #1;
      chk($sformatf("v%0d_count", i), int'(count), v.e_cnt);
      chk($sformatf("v%0d_ready", i), int'(alloc_ready), v.e_rdy);
      chk($sformatf("v%0d_tag0", i), int'(alloc_rob_addr0), v.e_t0);
      chk($sformatf("v%0d_tag1", i), int'(alloc_rob_addr1), v.e_t1);
      chk($sformatf("v%0d_retire0", i), int'(retire0), v.e_r0);
      chk($sformatf("v%0d_retire1", i), int'(retire1), v.e_r1);
      chk($sformatf("v%0d_rd_done0", i), int'(rd_done0), v.e_rdn);
      if (v.e_rdn != 0) chk($sformatf("v%0d_rd_data0", i), int'(rd_data0), v.e_rdd);
      if (v.e_r0 != 0) begin
        chk($sformatf("v%0d_ret_reg0", i), int'(retire_reg_addr0), v.e_rr0);
        chk($sformatf("v%0d_ret_tag0", i), int'(retire_rob_addr0), v.e_rtag);
        chk($sformatf("v%0d_ret_data0", i), int'(retire_data0), v.e_rd0);
      end
      if (v.e_r1 != 0) begin
        chk($sformatf("v%0d_ret_reg1", i), int'(retire_reg_addr1), v.e_rr1);
        chk($sformatf("v%0d_ret_tag1", i), int'(retire_rob_addr1), v.e_rtag + 1);
        chk($sformatf("v%0d_ret_data1", i), int'(retire_data1), v.e_rd1);
      end
      next();
    end

    // ---------------- fill, full, wrap ----------------
    do_reset();
    for (int k = 0; k < 15; k++) begin
      alloc0 = 1'b1; alloc1 = 1'b1;
      alloc_reg_addr0 = RW'(k); alloc_reg_addr1 = RW'(k + 1);
      next();
    end
    #1;
    chk("fill30_count", int'(count), 30);
    chk("fill30_ready", int'(alloc_ready), 1);
    chk("fill30_tag0", int'(alloc_rob_addr0), 30);
    alloc0 = 1'b1;
    next(); #1;
    chk("fill31_count", int'(count), 31);
    chk("fill31_ready", int'(alloc_ready), 0);
    alloc0 = 1'b1; alloc1 = 1'b1;
    next(); #1;
    chk("blocked_count", int'(count), 31);
    chk("blocked_tag0", int'(alloc_rob_addr0), 31);
    wb0 = 1'b1; wb_rob_addr0 = 5'd0; wb_data0 = 32'hA0;
    wb1 = 1'b1; wb_rob_addr1 = 5'd1; wb_data1 = 32'hA1;
    next(); #1;
    chk("full_retire0", int'(retire0), 1);
    chk("full_retire1", int'(retire1), 1);
    chk("full_ret_data1", int'(retire_data1), 'hA1);
    next(); #1;
    chk("drain_count", int'(count), 29);
    chk("drain_ready", int'(alloc_ready), 1);
    alloc0 = 1'b1;
    #1;
    chk("wrap_tag0", int'(alloc_rob_addr0), 31);
    chk("wrap_tag1", int'(alloc_rob_addr1), 0);
    next(); #1;
    chk("wrap_count", int'(count), 30);
    chk("wrap_tail", int'(alloc_rob_addr0), 0);
    alloc0 = 1'b1; alloc1 = 1'b1;
    next(); #1;
    chk("full_count", int'(count), 32);
    chk("full_ready", int'(alloc_ready), 0);

    // ---------------- flush of speculative tail ----------------
    do_reset();
    alloc0 = 1'b1; alloc1 = 1'b1; alloc_reg_addr0 = 5'd1; alloc_reg_addr1 = 5'd2;
    next();
    alloc0 = 1'b1; alloc1 = 1'b1; alloc_spec0 = 1'b1; alloc_spec1 = 1'b1;
    next();
    alloc0 = 1'b1; alloc_spec0 = 1'b1;
    next(); #1;
    chk("spec5_count", int'(count), 5);
    chk("spec5_tag0", int'(alloc_rob_addr0), 5);
    wb0 = 1'b1; wb_rob_addr0 = 5'd3; wb_data0 = 32'h33;
    next();
    rd_rob_addr0 = 5'd3;
    #1;
    chk("pre_flush_rd_done3", int'(rd_done0), 1);
    flush = 1'b1; alloc0 = 1'b1; alloc_reg_addr0 = 5'd9;
    next();
    rd_rob_addr0 = 5'd3;
    #1;
    chk("flush_count", int'(count), 2);
    chk("flush_tail", int'(alloc_rob_addr0), 2);
    chk("flush_rd_done3", int'(rd_done0), 0);
    alloc0 = 1'b1;
    next(); #1;
    chk("post_flush_count", int'(count), 3);

    // ---------------- spec_clear, flush+spec_clear ----------------
    do_reset();
    alloc0 = 1'b1; alloc1 = 1'b1; alloc_spec0 = 1'b1; alloc_spec1 = 1'b1;
    alloc_reg_addr0 = 5'd6; alloc_reg_addr1 = 5'd8;
    next();
    wb0 = 1'b1; wb_rob_addr0 = 5'd0; wb_data0 = 32'h66;
    wb1 = 1'b1; wb_rob_addr1 = 5'd1; wb_data1 = 32'h88;
    next();
    rd_rob_addr1 = 5'd1;
    #1;
    chk("spec_head_retire0", int'(retire0), 0);
    chk("spec_rd_done1", int'(rd_done1), 1);
    chk("spec_rd_data1", int'(rd_data1), 'h88);
    spec_clear = 1'b1; alloc0 = 1'b1; alloc_spec0 = 1'b1; alloc_reg_addr0 = 5'd10;
    next(); #1;
    chk("clr_count", int'(count), 3);
    chk("clr_retire0", int'(retire0), 1);
    chk("clr_retire1", int'(retire1), 1);
    chk("clr_ret_reg0", int'(retire_reg_addr0), 6);
    chk("clr_ret_data0", int'(retire_data0), 'h66);
    chk("clr_ret_reg1", int'(retire_reg_addr1), 8);
    flush = 1'b1; spec_clear = 1'b1;
    next(); #1;
    chk("fsc_count", int'(count), 0);
    chk("fsc_tail", int'(alloc_rob_addr0), 2);
    chk("fsc_retire0", int'(retire0), 0);

    // ---------------- asynchronous reset mid-stream ----------------
    do_reset();
    for (int k = 0; k < 3; k++) begin
      alloc0 = 1'b1; alloc1 = 1'b1;
      next();
    end
    alloc0 = 1'b1;
    next();
    wb0 = 1'b1; wb_rob_addr0 = 5'd0; wb_data0 = 32'h77;
    next(); #1;
    chk("pre_arst_count", int'(count), 7);
    chk("pre_arst_retire0", int'(retire0), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_retire0", int'(retire0), 0);
    chk("arst_ready", int'(alloc_ready), 1);
    @(negedge clk);
    reset = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular reorder buffer that allocates ROB entries at dispatch, collects writeback results and retires entries in program order, two per cycle.
- It produces the ROB tags pushed into the rename table at dispatch and the reg/tag pairs popped from it at retire.
- On mispredict it discards its speculative tail, in step with the rename-table flush.

Parameters:
NUM_ENTRIES, 32, ROB depth; power of two.
ROB_ADDR_W, 5, log2(NUM_ENTRIES); width of ROB tags.
REG_ADDR_W, 5, architectural register address width.
DATA_W, 32, result data width.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  asynchronous, active-low reset.
alloc0 / alloc1  in  1  allocate request, slot 0 / slot 1.
alloc_reg_addr0 / alloc_reg_addr1  in  REG_ADDR_W  destination register per slot.
alloc_spec0 / alloc_spec1  in  1  entry is speculative, per slot.
alloc_ready  out  1  at least 2 free entries.
alloc_rob_addr0 / alloc_rob_addr1  out  ROB_ADDR_W  tag assigned to slot 0 / slot 1.
wb0 / wb1  in  1  writeback valid, two ports.
wb_rob_addr0 / wb_rob_addr1  in  ROB_ADDR_W  writeback target tag.
wb_data0 / wb_data1  in  DATA_W  writeback result.
rd_rob_addr0 / rd_rob_addr1  in  ROB_ADDR_W  operand lookup tag.
rd_done0 / rd_done1  out  1  looked-up entry is valid and done.
rd_data0 / rd_data1  out  DATA_W  looked-up entry data.
spec_clear  in  1  branch resolved correct; clear every spec bit.
flush  in  1  branch mispredicted; discard all speculative entries.
retire0 / retire1  out  1  retire slot valid.
retire_reg_addr0 / retire_reg_addr1  out  REG_ADDR_W  retired destination register.
retire_rob_addr0 / retire_rob_addr1  out  ROB_ADDR_W  retired tag.
retire_data0 / retire_data1  out  DATA_W  retired result.
count  out  ROB_ADDR_W+1  number of occupied entries.

Behaviour:
- State:
  - per entry: valid, done, spec, reg_addr, data.
  - head and tail pointers, ROB_ADDR_W bits each; wrap modulo NUM_ENTRIES.
  - count register, 0..NUM_ENTRIES.
- Reset (reset=0, asynchronous):
  - head=tail=count=0; all valid/done/spec=0.
  - retire0/1=0, rd_done0/1=0, alloc_ready=1.
  - alloc_rob_addr0=0, alloc_rob_addr1=0.
- Tag assignment (combinational):
  - alloc_rob_addr0 = tail.
  - alloc_rob_addr1 = tail + alloc0, wrapping.
  - alloc_ready = (NUM_ENTRIES - count) >= 2.
- Allocate (posedge, alloc_ready=1):
  - each asserted slot writes valid=1, done=0, spec=alloc_specN, reg_addr at its tag.
  - tail advances by alloc0+alloc1.
  - Requests while alloc_ready=0 are ignored entirely; no state change.
- Writeback: wbN to a valid entry sets done=1 and data=wb_dataN. Writeback to an invalid entry is ignored. Both ports may hit the same tag in one cycle; port 1 wins.
- Read ports: combinational, no writeback bypass. A same-cycle writeback is visible the next cycle.
- Retire (combinational from current state; takes effect at posedge):
  - retire0 = valid & done & !spec at head.
  - retire1 = retire0 & valid & done & !spec at head+1.
  - Retired entries clear valid; head advances by retire0+retire1.
- count_next = count + accepted allocs - retires; simultaneous alloc and retire are legal.
- spec_clear: all spec bits become 0 at posedge. Same-cycle allocs keep their alloc_specN value.
- flush:
  - Speculative entries are contiguous youngest. All entries with spec=1 clear valid/done/spec.
  - tail = head + (number of valid non-spec entries), then adjusted for same-cycle retires; count updated to match.
  - Allocs in a flush cycle are ignored.
  - Retires in a flush cycle proceed normally.
  - flush and spec_clear together: flush wins.
- Full at count=NUM_ENTRIES; empty at count=0. Pointers wrap from NUM_ENTRIES-1 to 0.
- Reset mid-operation discards all contents immediately.

Test Plan:
- Reset then alloc0+alloc1 (r3, r4, non-spec) -> tags 0 and 1; count=2; next cycle alloc_rob_addr0=2.
- wb1 tag1 data 0xBEEF, then wb0 tag0 data 0x1234 -> following cycle retire0 (r3, tag0, 0x1234) and retire1 (r4, tag1, 0xBEEF) together; count=0.
- Fill to 30 entries -> alloc_ready=1. At 31 -> alloc_ready=0; an alloc pulse leaves count at 31. Retire 2 -> alloc_ready=1; tail wraps 31->0.
- Allocate 2 non-spec, then 3 spec entries (tags 2-4), then flush -> count=2; tail=2; rd_done on tag 3 = 0; the next alloc gets tag 2.
- Spec entry done at head -> no retire. After spec_clear -> retires next cycle.
- Assert reset low asynchronously, between clock edges, mid-stream with count=7 -> count=0 and retire0=0 before the next clock edge.
